// File: rtl/par8_pkg.sv
// Opcodes, sequencer state encoding and shared constants for the 8-bit
// parallel host bus command path.
package par8_pkg;

  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_START  = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] CMD_RESULT = 8'h04;
  localparam logic [7:0] CMD_DESYNC = 8'hFF;

  localparam logic [7:0] SYNC_BYTE_HI = 8'hB8;
  localparam logic [7:0] SYNC_BYTE_LO = 8'h8B;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_TX_STATUS = 3'd2,
    ST_RD_ADDR   = 3'd3,
    ST_RD_WAIT   = 3'd4,
    ST_TX_RESULT = 3'd5
  } state_e;

  // Index width that stays legal for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/par8_cmd_ctrl_if.sv
// Bundle of receiver, transmitter and hash-core signals seen by the
// command sequencer; master is the sequencer side.
interface par8_cmd_ctrl_if
  import par8_pkg::*;
#(
  parameter int RESULT_BYTES = 16
);
  localparam int AW = idx_width(RESULT_BYTES);

  logic [7:0]    rxd_data;
  logic          rxd_data_ready;
  logic          desync;
  logic [7:0]    txd_data;
  logic          txd_valid;
  logic          txd_ready_next;
  logic [7:0]    load_data;
  logic          load_valid;
  logic          load_last;
  logic          start;
  logic [7:0]    status_in;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          proto_err;

  modport master (
    input  rxd_data, rxd_data_ready, txd_ready_next, status_in, rd_data,
    output desync, txd_data, txd_valid, load_data, load_valid, load_last,
           start, rd_addr, proto_err
  );

  modport slave (
    output rxd_data, rxd_data_ready, txd_ready_next, status_in, rd_data,
    input  desync, txd_data, txd_valid, load_data, load_valid, load_last,
           start, rd_addr, proto_err
  );

endinterface

// File: rtl/par8_tx_pacer.sv
// Paces one response byte into the transmitter: strobes only when the
// transmitter is ready and keeps two quiet cycles after every strobe.
module par8_tx_pacer (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_i,
  input  logic [7:0] byte_i,
  input  logic       txd_ready_next_i,
  output logic [7:0] txd_data_o,
  output logic       txd_valid_o,
  output logic       done_o
);
  logic       armed_q, armed_d;
  logic [1:0] hold_q, hold_d;
  logic [7:0] data_q, data_d;
  logic       fire;

  // Arming one cycle after the request keeps the first strobe off the entry cycle.
  always_comb begin
    fire    = armed_q && txd_ready_next_i && (hold_q == 2'b00);
    armed_d = req_i && !fire;
    hold_d  = {hold_q[0], fire};
    data_d  = req_i ? byte_i : data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      hold_q  <= 2'b00;
      data_q  <= 8'h00;
    end else begin
      armed_q <= armed_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
    end
  end

  assign txd_data_o  = data_q;
  assign txd_valid_o = fire;
  assign done_o      = fire;

endmodule

// File: rtl/par8_cmd_ctrl.sv
// Command sequencer: decodes host bytes, streams LOAD payloads to the hash
// core, pulses START/DESYNC and returns STATUS/RESULT bytes through the pacer.
module par8_cmd_ctrl
  import par8_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 64,
  parameter int RESULT_BYTES  = 16
) (
  input logic             clk,
  input logic             reset,
  par8_cmd_ctrl_if.master bus
);
  localparam int CW = idx_width(PAYLOAD_BYTES);
  localparam int AW = idx_width(RESULT_BYTES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PAYLOAD_BYTES - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(RESULT_BYTES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [7:0]    load_data_q, load_data_d;
  logic          load_valid_q, load_valid_d;
  logic          load_last_q, load_last_d;
  logic          start_q, start_d;
  logic          desync_q, desync_d;
  logic          proto_err_q, proto_err_d;
  logic          tx_req, tx_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_addr_d    = rd_addr_q;
    tx_byte_d    = tx_byte_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    load_last_d  = 1'b0;
    start_d      = 1'b0;
    desync_d     = 1'b0;
    proto_err_d  = proto_err_q;
    tx_req       = (state_q == ST_TX_STATUS) || (state_q == ST_TX_RESULT);

    case (state_q)
      ST_IDLE: begin
        if (bus.rxd_data_ready) begin
          case (bus.rxd_data)
            CMD_LOAD: begin
              state_d = ST_LOAD;
              cnt_d   = '0;
            end
            CMD_START:  start_d = 1'b1;
            CMD_STATUS: begin
              tx_byte_d = bus.status_in;
              state_d   = ST_TX_STATUS;
            end
            CMD_RESULT: begin
              rd_addr_d = '0;
              state_d   = ST_RD_ADDR;
            end
            CMD_DESYNC: desync_d = 1'b1;
            default:    proto_err_d = 1'b1;
          endcase
        end
      end
      // Payload bytes are never decoded, so 0xFF here is plain data.
      ST_LOAD: begin
        if (bus.rxd_data_ready) begin
          load_data_d  = bus.rxd_data;
          load_valid_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            load_last_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_TX_STATUS: if (tx_done) state_d = ST_IDLE;
      ST_RD_ADDR:   state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        tx_byte_d = bus.rd_data;
        state_d   = ST_TX_RESULT;
      end
      ST_TX_RESULT: begin
        if (tx_done) begin
          if (rd_addr_q == ADDR_LAST) begin
            state_d = ST_IDLE;
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
            state_d   = ST_RD_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.rxd_data_ready && (state_q != ST_IDLE) && (state_q != ST_LOAD))
      proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_addr_q    <= '0;
      tx_byte_q    <= 8'h00;
      load_data_q  <= 8'h00;
      load_valid_q <= 1'b0;
      load_last_q  <= 1'b0;
      start_q      <= 1'b0;
      desync_q     <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_addr_q    <= rd_addr_d;
      tx_byte_q    <= tx_byte_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      load_last_q  <= load_last_d;
      start_q      <= start_d;
      desync_q     <= desync_d;
      proto_err_q  <= proto_err_d;
    end
  end

  par8_tx_pacer u_pacer (
    .clk              (clk),
    .reset            (reset),
    .req_i            (tx_req),
    .byte_i           (tx_byte_q),
    .txd_ready_next_i (bus.txd_ready_next),
    .txd_data_o       (bus.txd_data),
    .txd_valid_o      (bus.txd_valid),
    .done_o           (tx_done)
  );

  assign bus.load_data  = load_data_q;
  assign bus.load_valid = load_valid_q;
  assign bus.load_last  = load_last_q;
  assign bus.start      = start_q;
  assign bus.desync     = desync_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_par8_cmd_ctrl.sv
// Self-checking bench for par8_cmd_ctrl: single-byte command table plus
// LOAD/STATUS/RESULT sequences scored against expectation queues.
module tb_par8_cmd_ctrl;
  import par8_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  par8_cmd_ctrl_if #(.RESULT_BYTES(16)) bus ();

  par8_cmd_ctrl #(.PAYLOAD_BYTES(64), .RESULT_BYTES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         due;
  } load_exp_t;

  typedef struct {
    logic [7:0] cmd;
    logic       exp_start;
    logic       exp_desync;
    logic       exp_err;
  } vec_t;

  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  load_exp_t  load_exp[$];
  int         start_exp[$];
  int         desync_exp[$];
  logic [7:0] tx_exp[$];
  load_exp_t  le;
  int         tx_seen = 0;
  int         last_tx = -100;
  int         first_tx = -1;
  bit         rand_ready = 1'b0;
  logic       ready_fixed = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous result memory model: data follows address by one cycle.
  always @(posedge clk) bus.rd_data <= 8'h10 + 8'(bus.rd_addr);

  initial begin
    bus.txd_ready_next = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.txd_ready_next = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.load_valid) begin
        check("load_expected", 32'(load_exp.size() > 0), 32'd1);
        if (load_exp.size() > 0) begin
          le = load_exp.pop_front();
          check("load_data", 32'(bus.load_data), 32'(le.data));
          check("load_last", 32'(bus.load_last), 32'(le.last));
          check("load_cycle", 32'(cyc), 32'(le.due));
        end
        $display("load byte %02h last=%0b cycle %0d", bus.load_data, bus.load_last, cyc);
      end else if (bus.load_last) begin
        check("load_last_without_valid", 32'(bus.load_last), 32'd0);
      end
      if (bus.start) begin
        check("start_expected", 32'(start_exp.size() > 0), 32'd1);
        if (start_exp.size() > 0) check("start_cycle", 32'(cyc), 32'(start_exp.pop_front()));
        $display("start pulse cycle %0d", cyc);
      end
      if (bus.desync) begin
        check("desync_expected", 32'(desync_exp.size() > 0), 32'd1);
        if (desync_exp.size() > 0) check("desync_cycle", 32'(cyc), 32'(desync_exp.pop_front()));
        $display("desync pulse cycle %0d", cyc);
      end
      if (bus.txd_valid) begin
        check("tx_expected", 32'(tx_exp.size() > 0), 32'd1);
        if (tx_exp.size() > 0) check("tx_data", 32'(bus.txd_data), 32'(tx_exp.pop_front()));
        check("tx_ready_next", 32'(bus.txd_ready_next), 32'd1);
        check("tx_spacing", 32'((cyc - last_tx) >= 3), 32'd1);
        if (first_tx < 0) first_tx = cyc;
        last_tx = cyc;
        tx_seen++;
        $display("tx byte %02h cycle %0d", bus.txd_data, cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rxd_data       = b;
    bus.rxd_data_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rxd_data_ready = 1'b0;
    bus.rxd_data       = 8'h00;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_load_valid"}, 32'(bus.load_valid), 32'd0);
    check({tag, "_load_last"},  32'(bus.load_last),  32'd0);
    check({tag, "_load_data"},  32'(bus.load_data),  32'd0);
    check({tag, "_start"},      32'(bus.start),      32'd0);
    check({tag, "_desync"},     32'(bus.desync),     32'd0);
    check({tag, "_txd_valid"},  32'(bus.txd_valid),  32'd0);
    check({tag, "_txd_data"},   32'(bus.txd_data),   32'd0);
    check({tag, "_rd_addr"},    32'(bus.rd_addr),    32'd0);
    check({tag, "_proto_err"},  32'(bus.proto_err),  32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    load_exp.delete();
    start_exp.delete();
    desync_exp.delete();
    tx_exp.delete();
    @(posedge clk);
    @(negedge clk);
    check_zero(tag);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    last_tx = -100;
  endtask

  task automatic wait_tx_drain(input int bound);
    int n = 0;
    while (tx_exp.size() != 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tx_drain", 32'(tx_exp.size()), 32'd0);
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    vec_t       vecs[6];
    logic [7:0] b;
    int         cmd_cyc;
    int         n;

    vecs[0] = '{cmd: 8'h02, exp_start: 1'b1, exp_desync: 1'b0, exp_err: 1'b0};
    vecs[1] = '{cmd: 8'hFF, exp_start: 1'b0, exp_desync: 1'b1, exp_err: 1'b0};
    vecs[2] = '{cmd: 8'h7E, exp_start: 1'b0, exp_desync: 1'b0, exp_err: 1'b1};
    vecs[3] = '{cmd: 8'h00, exp_start: 1'b0, exp_desync: 1'b0, exp_err: 1'b1};
    vecs[4] = '{cmd: 8'h05, exp_start: 1'b0, exp_desync: 1'b0, exp_err: 1'b1};
    vecs[5] = '{cmd: 8'hFE, exp_start: 1'b0, exp_desync: 1'b0, exp_err: 1'b1};

    bus.rxd_data       = 8'h00;
    bus.rxd_data_ready = 1'b0;
    bus.status_in      = 8'h00;

    for (int i = 0; i < 6; i++) begin
      do_reset("reset");
      if (vecs[i].exp_start)  start_exp.push_back(cyc + 1);
      if (vecs[i].exp_desync) desync_exp.push_back(cyc + 1);
      send(vecs[i].cmd);
      idle(3);
      check("vec_proto_err", 32'(bus.proto_err), 32'(vecs[i].exp_err));
      check("vec_pulses_seen", 32'(start_exp.size() + desync_exp.size()), 32'd0);
    end

    // LOAD with back-to-back strobes, then prove the sequencer is back in IDLE.
    do_reset("reset");
    send(CMD_LOAD);
    for (int i = 0; i < 64; i++) begin
      load_exp.push_back('{data: 8'(i), last: 1'(i == 63), due: cyc + 1});
      send(8'(i));
    end
    idle(2);
    check("load_seq_drained", 32'(load_exp.size()), 32'd0);
    start_exp.push_back(cyc + 1);
    send(CMD_START);
    idle(2);
    check("load_then_start", 32'(start_exp.size()), 32'd0);
    check("load_proto_err", 32'(bus.proto_err), 32'd0);

    // Payload containing 0xFF and opcode-like bytes, with irregular gaps.
    send(CMD_LOAD);
    for (int i = 0; i < 64; i++) begin
      b = ((i % 16) == 5) ? 8'hFF : ((i % 16) == 9) ? 8'h01 : 8'($urandom);
      load_exp.push_back('{data: b, last: 1'(i == 63), due: cyc + 1});
      send(b);
      idle($urandom_range(0, 2));
    end
    idle(3);
    check("load_ff_drained", 32'(load_exp.size()), 32'd0);
    check("load_ff_proto_err", 32'(bus.proto_err), 32'd0);

    // STATUS: the value present at the command strobe is the one returned.
    bus.status_in = 8'hA5;
    tx_seen  = 0;
    first_tx = -1;
    cmd_cyc  = cyc;
    tx_exp.push_back(8'hA5);
    send(CMD_STATUS);
    bus.status_in = 8'h3C;
    wait_tx_drain(50);
    idle(10);
    check("status_count", 32'(tx_seen), 32'd1);
    check("status_latency", 32'((first_tx - cmd_cyc) >= 2), 32'd1);

    // RESULT with a randomly toggling transmitter ready.
    rand_ready = 1'b1;
    tx_seen  = 0;
    first_tx = -1;
    cmd_cyc  = cyc;
    for (int i = 0; i < 16; i++) tx_exp.push_back(8'h10 + 8'(i));
    send(CMD_RESULT);
    wait_tx_drain(1000);
    rand_ready = 1'b0;
    idle(10);
    check("result_count", 32'(tx_seen), 32'd16);
    check("result_latency", 32'((first_tx - cmd_cyc) >= 3), 32'd1);
    check("result_proto_err", 32'(bus.proto_err), 32'd0);

    // Ready held low parks the sequence; a strobe meanwhile is dropped.
    ready_fixed = 1'b0;
    tx_seen = 0;
    for (int i = 0; i < 16; i++) tx_exp.push_back(8'h10 + 8'(i));
    send(CMD_RESULT);
    idle(20);
    check("hold_no_tx", 32'(tx_seen), 32'd0);
    send(8'h55);
    idle(2);
    check("drop_proto_err", 32'(bus.proto_err), 32'd1);
    ready_fixed = 1'b1;
    wait_tx_drain(500);
    idle(5);
    check("drop_result_count", 32'(tx_seen), 32'd16);
    check("drop_no_load", 32'(load_exp.size()), 32'd0);

    // Reset after the fifth RESULT byte abandons the sequence.
    do_reset("reset");
    tx_seen = 0;
    for (int i = 0; i < 16; i++) tx_exp.push_back(8'h10 + 8'(i));
    send(CMD_RESULT);
    n = 0;
    while (tx_seen < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte5", 32'(tx_seen), 32'd5);
    @(posedge clk);
    #1;
    do_reset("midreset");
    idle(50);
    check("no_tx_after_reset", 32'(tx_seen), 32'd5);

    check("queues_empty", 32'(load_exp.size() + start_exp.size() + desync_exp.size() + tx_exp.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/par8_cmd_ctrl.md
# par8_cmd_ctrl

Command sequencer for the 8-bit parallel host bus. It parses the byte stream delivered by the parallel-bus receiver, dispatches LOAD, START, STATUS, RESULT and DESYNC commands to the hash datapath, and paces response bytes into the parallel-bus transmitter. It sits between the receiver/transmitter pair and the MD5 core.

## Interface
Parameters:
- `PAYLOAD_BYTES`, default 64: bytes following a LOAD command.
- `RESULT_BYTES`, default 16: bytes returned by a RESULT command.

Ports:
- `clk`  in  1  system clock (about 100 MHz).
- `reset`  in  1  synchronous, active-high.
- `rxd_data`  in  8  received byte; valid only while `rxd_data_ready` is high.
- `rxd_data_ready`  in  1  single-cycle strobe from the receiver.
- `desync`  out  1  single-cycle pulse to the receiver; forces it to re-sync.
- `txd_data`  out  8  byte to transmit.
- `txd_valid`  out  1  single-cycle strobe to the transmitter.
- `txd_ready_next`  in  1  transmitter can accept a byte next cycle.
- `load_data`  out  8  payload byte to the core.
- `load_valid`  out  1  payload byte strobe.
- `load_last`  out  1  high with the final payload byte.
- `start`  out  1  single-cycle core start pulse.
- `status_in`  in  8  core status, sampled on demand.
- `rd_addr`  out  clog2(RESULT_BYTES)  result byte address.
- `rd_data`  in  8  result byte, valid one cycle after `rd_addr` (synchronous read).
- `proto_err`  out  1  sticky; cleared only by reset.

## Operation
Command bytes:
- 0x01 LOAD
- 0x02 START
- 0x03 STATUS
- 0x04 RESULT
- 0xFF DESYNC

States:
- **IDLE**: on an `rxd_data_ready` strobe, decode `rxd_data`.
  - LOAD → LOAD state, byte counter cleared.
  - START → `start` pulse next cycle; stay in IDLE.
  - STATUS → TX_STATUS.
  - RESULT → RD_ADDR, `rd_addr`=0.
  - DESYNC → `desync` pulse next cycle; stay in IDLE.
  - Any other value → set `proto_err`; stay in IDLE.
- **LOAD**: each strobe forwards `rxd_data` on `load_data` with `load_valid`, registered, next cycle. The counter increments. The byte at count `PAYLOAD_BYTES-1` also asserts `load_last`, then returns to IDLE. Command decoding is suspended: 0xFF inside a payload is data.
- **TX_STATUS**: `status_in` is latched on entry. The byte is sent with the send rule, then returns to IDLE.
- **RD_ADDR → RD_WAIT → TX_RESULT**:
  - RD_WAIT spends one cycle waiting for `rd_data`.
  - TX_RESULT sends `rd_data` (latched) with the send rule.
  - If `rd_addr` == RESULT_BYTES-1 → IDLE; else `rd_addr` increments → RD_ADDR.
- **Send rule**: assert `txd_valid` for exactly one cycle in a cycle where `txd_ready_next`=1 and the holdoff is clear. The holdoff is set on the `txd_valid` cycle and on the following cycle, because the transmitter's busy flag rises one cycle late.
- **Strobes during TX_STATUS, RD_*, TX_RESULT**: the byte is dropped and `proto_err` is set. The sequence continues.
- **Counter width**: clog2(PAYLOAD_BYTES) counter, compared for equality. It never wraps past the terminal count.

## Timing
- **Reset values**: all outputs 0, state IDLE, counters 0, holdoff clear. A reset mid-LOAD or mid-RESULT abandons the sequence with no `load_last` and no further `txd_valid`.
- **Output latency**: `load_valid`, `start` and `desync` assert exactly 1 cycle after the triggering `rxd_data_ready`.
- **First response byte**:
  - STATUS: `txd_valid` no earlier than 2 cycles after the command strobe.
  - RESULT: `txd_valid` no earlier than 3 cycles after the command strobe.
- **Back-to-back**:
  - Consecutive `txd_valid` pulses are at least 3 cycles apart.
  - Consecutive `rxd_data_ready` strobes may arrive 1 cycle apart; LOAD accepts every one.
- **`txd_ready_next` low**: the controller holds its state indefinitely; there is no timeout.
- **Simultaneous events**: a strobe on the same cycle as the last LOAD byte's return to IDLE cannot occur, because the last byte is consumed in LOAD.

## Structure
- Shared package `par8_pkg`: command opcodes (CMD_LOAD, CMD_START, CMD_STATUS, CMD_RESULT, CMD_DESYNC), state encoding localparams, and sync byte constants 0xB8/0x8B.
- One natural sub-module, `par8_tx_pacer`: implements the send rule and holdoff. Inputs are a byte and a request; outputs are `txd_data`, `txd_valid` and `done`. It is reused by TX_STATUS and TX_RESULT.

## Test plan
- **Reset then LOAD**: 0x01 then bytes 0x00..0x3F → 64 `load_valid` pulses carrying 0x00..0x3F in order, each 1 cycle after its strobe; `load_last` only with 0x3F; state returns to IDLE.
- **Payload containing 0xFF**: LOAD payload includes 0xFF → forwarded as data; no `desync` pulse.
- **STATUS**: `status_in`=0xA5, command 0x03, `txd_ready_next` held high → exactly one `txd_valid` with `txd_data`=0xA5.
- **RESULT**: `rd_data` = 0x10+`rd_addr`, `txd_ready_next` toggled randomly → 16 `txd_valid` pulses carrying 0x10..0x1F, at least 3 cycles apart, none while ready is low.
- **Errors**: unknown opcode 0x7E → `proto_err`=1, no outputs. A strobe during TX_RESULT → byte dropped, `proto_err`=1, result sequence still completes.
- **DESYNC and reset**: 0xFF in IDLE → one-cycle `desync` pulse. Reset asserted at RESULT byte 5 → `txd_valid` stays 0 and all outputs are 0 the next cycle.
